i2c_slave_write_byte: RTL and testbench
=======================================

# i2c_slave_write_byte

Byte-level transmit controller for the I2C slave read-data path: it takes one byte from the slave top FSM and sequences `I2C_slave_write_bit` eight times, MSB first. It then releases SDA for the master's ACK/NACK slot, samples that slot and reports the result. It sits between the slave top-level FSM and the bit-level write datapath, and owns SDA for the whole 9-bit byte frame.

## Interface
Parameters:
- `BYTE_WIDTH`, default 8, number of data bits per frame; the counter width is $clog2(BYTE_WIDTH).

Ports:
- `clk`  input  1  system clock; all logic is on posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `byte_write_en`  input  1  level request from the slave FSM. Held high until `byte_write_finish`; deasserting it aborts the frame.
- `byte_write_i`  input  BYTE_WIDTH  byte to transmit; captured on the cycle the request starts.
- `byte_write_finish`  output  1  one-cycle pulse at the end of the ACK slot.
- `ack_o`  output  1  1 = master ACK (SDA low in the ACK slot), 0 = NACK. Valid from `byte_write_finish` until the next frame starts.
- `scl_i`  input  1  SCL, already synchronised to `clk` upstream.
- `sda_i`  input  1  SDA, already synchronised to `clk` upstream.
- `sda_o`  output  1  SDA drive value; 1 = release (open-drain high).

## Operation
- States:
  - IDLE: `sda_o`=1. On `byte_write_en`=1, go to DATA. Capture `byte_write_i` into the shift register and clear the bit counter.
  - DATA: assert `bit_write_en` to the sub-module, with `bit_write_i` = shift_reg[MSB]. On each sub-module `bit_write_finish`:
    - shift the register left by 1 and increment the counter;
    - when counter == BYTE_WIDTH-1, go to ACK and drop `bit_write_en` instead.
  - ACK: `sda_o`=1 (released). On an SCL rising edge, latch `ack_o` = ~`sda_i`. On the next SCL falling edge, pulse `byte_write_finish` and go to DONE.
  - DONE: hold `sda_o`=1. Wait for `byte_write_en`=0, then go to IDLE. A new frame needs a low-high request edge.
- Sub-module contract:
  - `bit_write_en` stays high across consecutive bits.
  - The sub-module drives `sda_o` with `bit_write_i` for the bit cell and pulses `bit_write_finish` at the cell's closing SCL fall.
  - The next bit value is present on `bit_write_i` from the cycle after that pulse.
- `sda_o` source: sub-module `sda_o` in DATA; constant 1 in every other state.
- Bit order is MSB first. The counter never wraps inside a frame; the transition to ACK happens at count BYTE_WIDTH-1 plus a finish pulse.
- Abort: `byte_write_en`=0 in DATA or ACK gives IDLE on the next cycle.
  - `sda_o`=1 and the sub-module is disabled the same cycle.
  - No finish pulse is generated and `ack_o` is unchanged.
- SCL edges come from a local `scl_last` register. Reset value of `scl_last` is 1.

## Timing
- Reset values: `sda_o`=1, `byte_write_finish`=0, `ack_o`=0, state IDLE, `scl_last`=1, shift register 0, counter 0.
- Request to first bit: DATA is entered one clk after `byte_write_en` rises. Bit 7 is driven from the next SCL low phase, per the sub-module contract.
- Frame length: 9 SCL periods (8 data + 1 ACK). `byte_write_finish` is registered: it asserts 1 clk after the clk that detects the ACK-slot SCL fall.
- `sda_o` is released within 1 clk after the 8th bit's `bit_write_finish`. This is always inside the SCL low phase, which gives hold margin to the master.
- Minimum SCL low phase: 2 clk cycles. Minimum SCL high phase: 1 clk cycle.
- If an SCL rise and an abort occur in the same cycle, the abort wins and `ack_o` is not updated.

## Structure
- Shared package `I2C_pkg`: state encodings (IDLE/DATA/ACK/DONE) and the I2C ACK/NACK level constants.
- One sub-module: the existing `I2C_slave_write_bit`, instantiated once.
- The edge detector is local (two lines); it is not a separate module.

## Test plan
- Byte 8'hA5 with the master driving ACK (SDA low on the 9th rise): SDA shows 1,0,1,0,0,1,0,1 on the SCL rises; SDA is 1 on the 9th; one `byte_write_finish` pulse; `ack_o`=1.
- Byte 8'h3C with the master leaving SDA high on the 9th rise: `ack_o`=0, finish pulses once, FSM waits in DONE until en drops.
- Back-to-back bytes 8'h00 then 8'hFF, with en re-raised the cycle after the drop: the bit patterns are correct with no extra SCL period, and `ack_o` is updated per byte.
- Abort by dropping en after the 4th SCL rise of 8'hF0: `sda_o`=1 the next cycle, no finish pulse, next request 8'h81 transmits correctly.
- Assert `rst_n`=0 mid-frame (bit 5): all outputs take their reset values asynchronously; after release, byte 8'h55 completes with `ack_o`=1.
- Run 32 random bytes at SCL divisors 4 and 10, with a scoreboard comparing the sampled bits against the requests: 0 errors.

Source files
------------

// File: rtl/i2c_slave_write_byte_pkg.sv
// Shared definitions for the I2C slave byte-transmit path.
// Holds the byte-controller state encoding and the SDA levels that the
// master uses to signal ACK / NACK in the ninth bit slot.
package i2c_slave_write_byte_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } byte_state_t;

    // SDA level seen in the ACK slot: low = ACK, high (released) = NACK.
    localparam logic I2C_ACK_LEVEL  = 1'b0;
    localparam logic I2C_NACK_LEVEL = 1'b1;

endpackage

// File: rtl/i2c_slave_write_byte_bit.sv
// Bit-level SDA driver for the I2C slave transmit path.
// While enabled it drives one bit cell per SCL period and pulses
// bit_write_finish on the SCL fall that closes each cell. Driving only
// starts once SCL is seen low, so SDA never moves while SCL is high.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bit_write_en      level enable, held across consecutive bits
//   bit_write_i       bit to drive for the current cell
//   scl_i             synchronised SCL
//   sda_o             SDA drive value, 1 = released
//   bit_write_finish  one-cycle pulse at the closing SCL fall of a cell
module i2c_slave_write_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_write_en,
    input  logic bit_write_i,
    input  logic scl_i,
    output logic sda_o,
    output logic bit_write_finish
);

    logic active;
    logic scl_last;

    // Gated with the enable so that an abort releases SDA in the same cycle.
    // The value follows bit_write_i directly so the next bit appears right
    // after the controller shifts, well inside the SCL low phase.
    assign sda_o = (bit_write_en && active) ? bit_write_i : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active           <= 1'b0;
            scl_last         <= 1'b1;
            bit_write_finish <= 1'b0;
        end else begin
            scl_last         <= scl_i;
            bit_write_finish <= 1'b0;
            if (!bit_write_en) begin
                active <= 1'b0;
            end else if (!active) begin
                if (!scl_i) begin
                    active <= 1'b1;
                end
            end else if (scl_last && !scl_i) begin
                // Started in a low phase, so any fall seen now closes a cell.
                bit_write_finish <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_write_byte.sv
// Byte-level transmit controller for the I2C slave read-data path.
// Sends one byte MSB first through the bit driver, releases SDA for the
// master's ACK slot, samples it and reports the result.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   byte_write_en      level request; dropping it aborts the frame
//   byte_write_i       byte to send, captured when the request starts
//   byte_write_finish  one-cycle pulse at the end of the ACK slot
//   ack_o              1 = master ACK, 0 = NACK
//   scl_i, sda_i       synchronised bus inputs
//   sda_o              SDA drive value, 1 = released
module i2c_slave_write_byte
    import i2c_slave_write_byte_pkg::*;
#(
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  byte_write_en,
    input  logic [BYTE_WIDTH-1:0] byte_write_i,
    output logic                  byte_write_finish,
    output logic                  ack_o,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o
);

    localparam int CW = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(BYTE_WIDTH - 1);

    byte_state_t           state;
    logic [BYTE_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         count;
    logic                  scl_last;
    logic                  scl_rise;
    logic                  scl_fall;
    logic                  bit_write_en;
    logic                  bit_sda;
    logic                  bit_write_finish;

    assign scl_rise = scl_i && !scl_last;
    assign scl_fall = !scl_i && scl_last;

    // Request is folded in combinationally so an abort disables the bit
    // driver and releases SDA without waiting for the state change.
    assign bit_write_en = (state == ST_DATA) && byte_write_en;
    assign sda_o        = bit_write_en ? bit_sda : 1'b1;

    i2c_slave_write_bit u_bit (
        .clk              (clk),
        .rst_n            (rst_n),
        .bit_write_en     (bit_write_en),
        .bit_write_i      (shift_reg[BYTE_WIDTH-1]),
        .scl_i            (scl_i),
        .sda_o            (bit_sda),
        .bit_write_finish (bit_write_finish)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            shift_reg         <= '0;
            count             <= '0;
            scl_last          <= 1'b1;
            byte_write_finish <= 1'b0;
            ack_o             <= 1'b0;
        end else begin
            scl_last          <= scl_i;
            byte_write_finish <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (byte_write_en) begin
                        shift_reg <= byte_write_i;
                        count     <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!byte_write_en) begin
                        state <= ST_IDLE;
                    end else if (bit_write_finish) begin
                        shift_reg <= shift_reg << 1;
                        // Counter stops at the last bit rather than wrapping.
                        if (count == LAST_BIT) begin
                            state <= ST_ACK;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    // Abort takes priority over a coincident SCL rise.
                    if (!byte_write_en) begin
                        state <= ST_IDLE;
                    end else begin
                        if (scl_rise) begin
                            ack_o <= (sda_i == I2C_ACK_LEVEL);
                        end
                        if (scl_fall) begin
                            byte_write_finish <= 1'b1;
                            state             <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // A new frame requires the request to go low first.
                    if (!byte_write_en) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_write_byte.sv
module tb_i2c_slave_write_byte;

    logic       clk;
    logic       rst_n;
    logic       byte_write_en;
    logic [7:0] byte_write_i;
    logic       byte_write_finish;
    logic       ack_o;
    logic       scl;
    logic       mdrv;
    logic       sda_line;
    logic       sda_o;

    int n_total = 0;
    int n_bad   = 0;
    int fin_cnt = 0;
    logic exp_ack;

    assign sda_line = sda_o & mdrv;

    i2c_slave_write_byte #(.BYTE_WIDTH(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .byte_write_en     (byte_write_en),
        .byte_write_i      (byte_write_i),
        .byte_write_finish (byte_write_finish),
        .ack_o             (ack_o),
        .scl_i             (scl),
        .sda_i             (sda_line),
        .sda_o             (sda_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && byte_write_finish) fin_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Master side of one full 9-bit frame; SCL is low on entry and exit.
    task automatic do_frame(input logic [7:0] data, input int div, input bit mack, input bit drop_en);
        logic [7:0] bits;
        logic       sda9;
        logic       rel9;
        int         f0;
        int         half;
        half = div / 2;
        bits = 8'h00;
        sda9 = 1'b0;
        rel9 = 1'b0;
        f0 = fin_cnt;
        byte_write_en = 1'b1;
        byte_write_i  = data;
        repeat (2) @(negedge clk);
        for (int b = 0; b < 9; b++) begin
            if (b == 8) mdrv = mack ? 1'b0 : 1'b1;
            repeat (half) @(negedge clk);
            if (b < 8) bits[7-b] = sda_line;
            else begin
                sda9 = sda_line;
                rel9 = sda_o;
            end
            scl = 1'b1;
            repeat (half) @(negedge clk);
            scl = 1'b0;
            if (b == 8) mdrv = 1'b1;
        end
        repeat (3) @(negedge clk);
        $display("frame data=%02h div=%0d mack=%0d bits=%02h ack_o=%0d fin=%0d",
                 data, div, mack, bits, ack_o, fin_cnt - f0);
        check_val("bits", 32'(bits), 32'(data));
        check_val("sda9_line", 32'(sda9), mack ? 32'd0 : 32'd1);
        check_val("sda9_released", 32'(rel9), 32'd1);
        check_val("finish_count", 32'(fin_cnt - f0), 32'd1);
        check_val("ack_o", 32'(ack_o), 32'(mack));
        exp_ack = mack;
        if (drop_en) begin
            byte_write_en = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] pbits;
        int         f0;
        scl = 1'b0;
        mdrv = 1'b1;
        byte_write_en = 1'b0;
        byte_write_i = 8'h00;
        exp_ack = 1'b0;
        pbits = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_sda_o", 32'(sda_o), 32'd1);
        check_val("rst_finish", 32'(byte_write_finish), 32'd0);
        check_val("rst_ack", 32'(ack_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ACK from master
        do_frame(8'hA5, 4, 1'b1, 1'b1);

        // NACK, then request held high: controller must sit in DONE
        do_frame(8'h3C, 4, 1'b0, 1'b0);
        f0 = fin_cnt;
        repeat (20) @(negedge clk);
        check_val("done_no_refinish", 32'(fin_cnt - f0), 32'd0);
        check_val("done_sda_released", 32'(sda_o), 32'd1);
        byte_write_en = 1'b0;
        @(negedge clk);

        // Back-to-back with a single-cycle request gap
        do_frame(8'h00, 6, 1'b1, 1'b1);
        do_frame(8'hFF, 6, 1'b0, 1'b1);

        // Abort after the 4th SCL rise of 8'hF0
        f0 = fin_cnt;
        byte_write_en = 1'b1;
        byte_write_i  = 8'hF0;
        repeat (2) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            repeat (2) @(negedge clk);
            pbits[7-b] = sda_line;
            scl = 1'b1;
            if (b == 3) byte_write_en = 1'b0;
            else begin
                repeat (2) @(negedge clk);
                scl = 1'b0;
            end
        end
        @(negedge clk);
        check_val("abort_sda_o", 32'(sda_o), 32'd1);
        check_val("abort_bits", 32'(pbits[7:4]), 32'hF);
        @(negedge clk);
        scl = 1'b0;
        for (int p = 0; p < 2; p++) begin
            repeat (2) @(negedge clk);
            scl = 1'b1;
            repeat (2) @(negedge clk);
            scl = 1'b0;
        end
        repeat (3) @(negedge clk);
        $display("abort data=f0 bits7_4=%01h fin=%0d ack_o=%0d", pbits[7:4], fin_cnt - f0, ack_o);
        check_val("abort_no_finish", 32'(fin_cnt - f0), 32'd0);
        check_val("abort_ack_kept", 32'(ack_o), 32'(exp_ack));
        do_frame(8'h81, 4, 1'b1, 1'b1);

        // Asynchronous reset during bit 5 of 8'hC0
        byte_write_en = 1'b1;
        byte_write_i  = 8'hC0;
        repeat (2) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            repeat (2) @(negedge clk);
            pbits[7-b] = sda_line;
            scl = 1'b1;
            if (b < 2) begin
                repeat (2) @(negedge clk);
                scl = 1'b0;
            end
        end
        @(negedge clk);
        check_val("prereset_bits", 32'(pbits[7:5]), 32'h6);
        check_val("prereset_sda_o", 32'(sda_o), 32'd0);
        rst_n = 1'b0;
        byte_write_en = 1'b0;
        #1;
        $display("reset mid-frame sda_o=%0d fin=%0d ack_o=%0d", sda_o, byte_write_finish, ack_o);
        check_val("async_rst_sda_o", 32'(sda_o), 32'd1);
        check_val("async_rst_finish", 32'(byte_write_finish), 32'd0);
        check_val("async_rst_ack", 32'(ack_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scl = 1'b0;
        repeat (3) @(negedge clk);
        do_frame(8'h55, 4, 1'b1, 1'b1);

        // Random bytes at two SCL divisors
        for (int i = 0; i < 32; i++) begin
            do_frame(8'($urandom), (i < 16) ? 4 : 10, bit'($urandom_range(0, 1)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
